// File: rtl/pix_mem_arbiter.sv
// Pixel-memory port arbiter: display fetches win, host writes queue in a FIFO.
// Ports: clk_25/rst; disp_* feeder side; host_wr_*/host_rd_* host side;
//   mem_* memory port; fifo_level occupancy; bad_addr sticky range error.
module pix_mem_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int PIX_COUNT  = 3072
) (
  input  logic        clk_25,
  input  logic        rst,
  input  logic        disp_mem_read,
  input  logic        disp_mem_row,
  input  logic [8:0]  disp_addr,
  input  logic [2:0]  disp_pix_sel,
  output logic [3:0]  disp_pixel,
  input  logic        host_wr_valid,
  output logic        host_wr_ready,
  input  logic [11:0] host_wr_addr,
  input  logic [3:0]  host_wr_data,
  input  logic        host_rd_valid,
  output logic        host_rd_ready,
  input  logic [11:0] host_rd_addr,
  output logic [3:0]  host_rd_data,
  output logic        host_rd_done,
  output logic [8:0]  mem_addr,
  output logic [2:0]  mem_pix_sel,
  output logic        mem_we,
  output logic [3:0]  mem_wdata,
  input  logic [3:0]  mem_rdata,
  output logic [2:0]  fifo_level,
  output logic        bad_addr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_ONE  = 1;
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] P_ONE  = 1;
  localparam logic [12:0]   LIMIT  = 13'(PIX_COUNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD
  } state_t;

  state_t state_q, state_d;

  logic [11:0]   fa_q [FIFO_DEPTH];
  logic [3:0]    fd_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          rd_pend_q, rd_pend_d;
  logic [11:0]   rd_addr_q, rd_addr_d;
  logic [3:0]    rd_data_q, rd_data_d;
  logic          done_q, done_d;
  logic          bad_q, bad_d;

  logic host_ok;
  logic wr_acc, wr_bad, push, pop;
  logic rd_acc, rd_bad, rd_ok;
  logic rd_go, wr_avail;

  assign host_ok  = !disp_mem_row && !disp_mem_read;

  assign host_wr_ready = (cnt_q != C_FULL);
  assign host_rd_ready = (cnt_q == '0) && !rd_pend_q && (state_q == S_IDLE);

  assign wr_acc = host_wr_valid && host_wr_ready;
  assign wr_bad = {1'b0, host_wr_addr} >= LIMIT;
  assign push   = wr_acc && !wr_bad;

  assign rd_acc = host_rd_valid && host_rd_ready;
  assign rd_bad = {1'b0, host_rd_addr} >= LIMIT;
  assign rd_ok  = rd_acc && !rd_bad;

  // A request accepted this edge is already eligible to start, so the
  // memory cycle lands in the very next clock.
  assign rd_go    = rd_pend_q || rd_ok;
  assign wr_avail = (cnt_q != '0) || push;

  // A host cycle that overlaps a display read is lost and must be retried.
  assign pop = (state_q == S_WR) && !disp_mem_read;

  assign disp_pixel   = mem_rdata;
  assign fifo_level   = 3'(cnt_q);
  assign host_rd_data = rd_data_q;
  assign host_rd_done = done_q;
  assign bad_addr     = bad_q;

  always_comb begin
    state_d   = state_q;
    rd_pend_d = rd_pend_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    bad_d     = bad_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q;

    if (wr_acc && wr_bad) bad_d = 1'b1;

    if (rd_acc) begin
      if (rd_bad) begin
        bad_d     = 1'b1;
        rd_data_d = 4'h0;
        done_d    = 1'b1;
      end else begin
        rd_pend_d = 1'b1;
        rd_addr_d = host_rd_addr;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (host_ok) begin
          if (rd_go)         state_d = S_RD;
          else if (wr_avail) state_d = S_WR;
        end
      end
      S_WR: state_d = S_IDLE;
      S_RD: begin
        state_d = S_IDLE;
        if (!disp_mem_read) begin
          rd_data_d = mem_rdata;
          done_d    = 1'b1;
          rd_pend_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wp_d = wp_q + P_ONE;
    if (pop)  rp_d = rp_q + P_ONE;
    if (push && !pop)      cnt_d = cnt_q + C_ONE;
    else if (!push && pop) cnt_d = cnt_q - C_ONE;
  end

  always_comb begin
    mem_addr    = 9'h0;
    mem_pix_sel = 3'h0;
    mem_we      = 1'b0;
    mem_wdata   = 4'h0;
    if (disp_mem_read) begin
      mem_addr    = disp_addr;
      mem_pix_sel = disp_pix_sel;
    end else if (state_q == S_WR) begin
      mem_addr    = fa_q[rp_q][11:3];
      mem_pix_sel = fa_q[rp_q][2:0];
      mem_wdata   = fd_q[rp_q];
      mem_we      = 1'b1;
    end else if (state_q == S_RD) begin
      mem_addr    = rd_addr_q[11:3];
      mem_pix_sel = rd_addr_q[2:0];
    end
  end

  always_ff @(posedge clk_25 or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= 12'h0;
      rd_data_q <= 4'h0;
      done_q    <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      done_q    <= done_d;
      bad_q     <= bad_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk_25) begin
    if (push) begin
      fa_q[wp_q] <= host_wr_addr;
      fd_q[wp_q] <= host_wr_data;
    end
  end

endmodule
